// File: rtl/lcd_bus_sequencer.sv
// Avalon-MM slave that queues LCD command/data bytes and replays them
// onto an HD44780-style 8-bit bus with programmed setup/pulse/hold/wait.
module lcd_bus_sequencer #(
  parameter int unsigned SETUP_CYC    = 4,
  parameter int unsigned PULSE_CYC    = 12,
  parameter int unsigned HOLD_CYC     = 4,
  parameter int unsigned CMD_WAIT_CYC = 2000,
  parameter int unsigned CLR_WAIT_CYC = 82000,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [7:0]  lcd_data,
  output logic        lcd_rs,
  output logic        lcd_en,
  output logic        lcd_rw
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  localparam int unsigned MAX_A = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int unsigned MAX_B = (HOLD_CYC > CMD_WAIT_CYC) ? HOLD_CYC : CMD_WAIT_CYC;
  localparam int unsigned MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned MAX_CYC = (MAX_C > CLR_WAIT_CYC) ? MAX_C : CLR_WAIT_CYC;
  localparam int CNT_W = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] CMD_LD   = CNT_W'(CMD_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] CLR_LD   = CNT_W'(CLR_WAIT_CYC - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_WAIT
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       data_q, data_d;
  logic             rs_q, rs_d;
  logic             clr_q, clr_d;
  logic [8:0]       mem_q [FIFO_DEPTH];
  logic [8:0]       mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wp_q, wp_d;
  logic [PTR_W-1:0] rp_q, rp_d;
  logic [LVL_W-1:0] lvl_q, lvl_d;
  logic             ovf_q, ovf_d;

  logic       wr_en;
  logic       push_req;
  logic       push;
  logic       pop;
  logic       drop;
  logic       full;
  logic       empty;
  logic       busy;
  logic [8:0] head;
  logic [3:0] lvl4;
  logic       unused_wd;

  assign wr_en    = chipselect & ~write_n;
  assign push_req = wr_en & ((address == 2'd0) | (address == 2'd1));
  assign full     = (lvl_q == LVL_FULL);
  assign empty    = (lvl_q == '0);
  assign head     = mem_q[rp_q];
  assign push     = push_req & (~full | pop);
  assign drop     = push_req & ~push;
  assign busy     = (state_q != S_IDLE) | ~empty;
  assign lvl4     = 4'(lvl_q);
  assign unused_wd = ^writedata[31:8];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    rs_d    = rs_q;
    clr_d   = clr_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        pop = ~empty;
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          state_d = S_PULSE;
          cnt_d   = PULSE_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_PULSE: begin
        if (cnt_q == '0) begin
          state_d = S_HOLD;
          cnt_d   = HOLD_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          state_d = S_WAIT;
          cnt_d   = clr_q ? CLR_LD : CMD_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          pop     = ~empty;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A queued byte pops on the very edge the previous one finishes.
    if (pop) begin
      state_d = S_SETUP;
      cnt_d   = SETUP_LD;
      data_d  = head[7:0];
      rs_d    = head[8];
      clr_d   = ~head[8] & ((head[7:0] == 8'h01) | (head[7:0] == 8'h02));
    end
  end

  always_comb begin
    mem_d = mem_q;
    wp_d  = wp_q;
    rp_d  = rp_q;
    lvl_d = lvl_q;
    ovf_d = ovf_q;
    if (push) begin
      mem_d[wp_q] = {(address == 2'd0), writedata[7:0]};
      wp_d        = wp_q + 1'b1;
    end
    if (pop) begin
      rp_d = rp_q + 1'b1;
    end
    if (push && !pop) begin
      lvl_d = lvl_q + 1'b1;
    end else if (pop && !push) begin
      lvl_d = lvl_q - 1'b1;
    end
    if (wr_en && (address == 2'd3) && writedata[2]) begin
      ovf_d = 1'b0;
    end
    if (drop) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      rs_q    <= 1'b0;
      clr_q   <= 1'b0;
      wp_q    <= '0;
      rp_q    <= '0;
      lvl_q   <= '0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      rs_q    <= rs_d;
      clr_q   <= clr_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      lvl_q   <= lvl_d;
      ovf_q   <= ovf_d;
      mem_q   <= mem_d;
    end
  end

  always_comb begin
    readdata = '0;
    unique case (address)
      2'd2:    readdata = {24'h0, lvl4, 1'b0, ovf_q, full, busy};
      default: readdata = '0;
    endcase
  end

  assign lcd_en   = (state_q == S_PULSE);
  assign lcd_rw   = 1'b0;
  assign lcd_data = data_q;
  assign lcd_rs   = rs_q;

endmodule
